// File: rtl/nibbler_pkg.sv
// Shared parameters, control-word field positions and phase encoding for the
// nibble-processor fetch sequencer.
package nibbler_pkg;

   localparam int AW_DEF = 12;
   localparam int IW_DEF = 8;
   localparam int CW_DEF = 16;

   localparam int CW_PC_INC       = 15;
   localparam int CW_PC_LOAD_N    = 14;
   localparam int CW_FLAGS_LOAD_N = 1;

   typedef enum logic {
      PH_FETCH = 1'b0,
      PH_EXEC  = 1'b1
   } phase_e;

endpackage

// File: rtl/nibbler_pc.sv
// Program counter: load has priority over increment; increment wraps modulo 2^AW.
import nibbler_pkg::*;

module nibbler_pc #(
   parameter int AW = AW_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          en,
   input  logic          load,
   input  logic          inc,
   input  logic [AW-1:0] load_val,
   output logic [AW-1:0] pc
);

   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;

   always_comb begin
      pc_d = pc_q;
      if (en) begin
         if (load) begin
            pc_d = load_val;
         end else if (inc) begin
            pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Two-phase fetch/execute sequencer for a 4-bit nibble processor.
// Optional macro FETCH_STALL_EN adds a stall input that freezes all state.
//
// state    | meaning
// PH_FETCH | ir captures prog_data at the end of this phase
// PH_EXEC  | ir holds; flags may load from the ALU
import nibbler_pkg::*;

module fetch_sequencer #(
   parameter int AW = AW_DEF,
   parameter int IW = IW_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [IW-1:0] prog_data,
   input  logic [CW-1:0] ctrl_word,
   input  logic          carry_in,
   input  logic          zero_in,
`ifdef FETCH_STALL_EN
   input  logic          stall,
`endif
   output logic [AW-1:0] prog_addr,
   output logic [6:0]    ctrl_addr,
   output logic [3:0]    operand,
   output logic          phase,
   output logic          carry_flag,
   output logic          zero_flag
);

   phase_e        phase_q, phase_d;
   logic [IW-1:0] ir_q, ir_d;
   logic          carry_q, carry_d;
   logic          zero_q, zero_d;
   logic          advance;
   logic          pc_inc;
   logic          pc_load_n;
   logic          flags_load_n;
   logic [AW-1:0] pc_load_val;

`ifdef FETCH_STALL_EN
   assign advance = ~stall;
`else
   assign advance = 1'b1;
`endif

   assign pc_inc       = ctrl_word[CW_PC_INC];
   assign pc_load_n    = ctrl_word[CW_PC_LOAD_N];
   assign flags_load_n = ctrl_word[CW_FLAGS_LOAD_N];
   // Jump target is the operand nibble of the current ir followed by the next ROM byte.
   assign pc_load_val  = AW'({ir_q[3:0], prog_data});

   always_comb begin
      phase_d = phase_q;
      ir_d    = ir_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      if (advance) begin
         case (phase_q)
            PH_FETCH: begin
               ir_d    = prog_data;
               phase_d = PH_EXEC;
            end
            PH_EXEC: begin
               if (!flags_load_n) begin
                  carry_d = carry_in;
                  zero_d  = zero_in;
               end
               phase_d = PH_FETCH;
            end
            default: phase_d = PH_FETCH;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase_q <= PH_FETCH;
         ir_q    <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         ir_q    <= ir_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
      end
   end

   nibbler_pc #(.AW(AW)) u_pc (
      .clock    (clock),
      .reset    (reset),
      .en       (advance),
      .load     (~pc_load_n),
      .inc      (pc_inc),
      .load_val (pc_load_val),
      .pc       (prog_addr)
   );

   assign ctrl_addr  = {ir_q[7:4], ~carry_q, ~zero_q, phase_q};
   assign operand    = ir_q[3:0];
   assign phase      = phase_q;
   assign carry_flag = carry_q;
   assign zero_flag  = zero_q;

   // Control-word bits outside the three decoded fields belong to the datapath.
   logic unused_ok;
   assign unused_ok = ^{ctrl_word, ir_q};

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a behavioural model.
module tb_fetch_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  prog_data = 8'h00;
   logic [15:0] ctrl_word = 16'h0000;
   logic        carry_in = 1'b0;
   logic        zero_in = 1'b0;
   logic        stall_tb = 1'b0;
   logic [11:0] prog_addr;
   logic [6:0]  ctrl_addr;
   logic [3:0]  operand;
   logic        phase;
   logic        carry_flag;
   logic        zero_flag;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_pc, m_ir, m_ph, m_cf, m_zf;

   fetch_sequencer dut (
      .clock      (clock),
      .reset      (reset),
      .prog_data  (prog_data),
      .ctrl_word  (ctrl_word),
      .carry_in   (carry_in),
      .zero_in    (zero_in),
`ifdef FETCH_STALL_EN
      .stall      (stall_tb),
`endif
      .prog_addr  (prog_addr),
      .ctrl_addr  (ctrl_addr),
      .operand    (operand),
      .phase      (phase),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_ir = 0; m_ph = 0; m_cf = 0; m_zf = 0;
   endtask

   task automatic model_step(input int pd, input int cw, input int ci, input int zi, input int st);
      int npc;
      if (st != 0) return;
      if (((cw >> 14) & 1) == 0)
         npc = ((m_ir & 15) * 256) + pd;
      else if (((cw >> 15) & 1) == 1)
         npc = (m_pc + 1) % 4096;
      else
         npc = m_pc;
      if (m_ph == 0)
         m_ir = pd;
      else if (((cw >> 1) & 1) == 0) begin
         m_cf = ci;
         m_zf = zi;
      end
      m_pc = npc;
      m_ph = 1 - m_ph;
   endtask

   task automatic check_all(input string tag);
      int exp_ca;
      exp_ca = ((m_ir / 16) * 8) + ((1 - m_cf) * 4) + ((1 - m_zf) * 2) + m_ph;
      check({tag, ".pc"}, prog_addr, m_pc);
      check({tag, ".ca"}, ctrl_addr, exp_ca);
      check({tag, ".op"}, operand, m_ir % 16);
      check({tag, ".ph"}, phase, m_ph);
      check({tag, ".cf"}, carry_flag, m_cf);
      check({tag, ".zf"}, zero_flag, m_zf);
   endtask

   task automatic cycle(input logic [7:0] pd, input logic [15:0] cw, input logic ci,
                        input logic zi, input logic st, input string tag);
      prog_data = pd;
      ctrl_word = cw;
      carry_in  = ci;
      zero_in   = zi;
      stall_tb  = st;
      @(posedge clock);
      model_step(int'(pd), int'(cw), int'(ci), int'(zi), int'(st));
      @(negedge clock);
      stall_tb = 1'b0;
      check_all(tag);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clock);
      #2 reset = 1'b1;
      model_reset();
      #1 check_all(tag);
      #1 reset = 1'b0;
   endtask

   initial begin
      logic [6:0] ca;
      logic [1:0] fl;
      model_reset();
      @(negedge clock);
      check_all("reset");
      check("reset.ca_const", ctrl_addr, 7'b0000110);
      reset = 1'b0;

      // first fetch after reset
      cycle(8'hA3, 16'hF837, 1'b0, 1'b0, 1'b0, "fetch0");
      check("fetch0.op_const", operand, 4'h3);
      check("fetch0.pc_const", prog_addr, 12'h001);
      check("fetch0.ca_const", ctrl_addr, 7'b1010111);

      // jump plus flag load in execute
      cycle(8'h00, 16'h4002, 1'b0, 1'b0, 1'b0, "hold_exec");
      cycle(8'hC5, 16'hC002, 1'b0, 1'b0, 1'b0, "fetch_c5");
      cycle(8'h7E, 16'h0000, 1'b1, 1'b0, 1'b0, "jump");
      check("jump.pc_const", prog_addr, 12'h57E);
      check("jump.ph_const", phase, 1'b0);
      check("flags.cf_const", carry_flag, 1'b1);
      check("flags.zf_const", zero_flag, 1'b0);
      ca = ctrl_addr;
      fl = ca[2:1];
      check("flags.ca21", fl, 2'b01);

      // load priority over inc, then wrap from 0xFFF
      cycle(8'hFF, 16'hC002, 1'b0, 1'b0, 1'b0, "fetch_ff");
      cycle(8'hFF, 16'h8002, 1'b0, 1'b0, 1'b0, "load_fff");
      check("load_fff.pc_const", prog_addr, 12'hFFF);
      cycle(8'h00, 16'hC002, 1'b0, 1'b0, 1'b0, "wrap");
      check("wrap.pc_const", prog_addr, 12'h000);

      // async reset mid-instruction with pc = 0x123
      cycle(8'h00, 16'h4002, 1'b0, 1'b0, 1'b0, "hold2");
      cycle(8'h01, 16'hC002, 1'b0, 1'b0, 1'b0, "fetch_01");
      cycle(8'h23, 16'h0002, 1'b0, 1'b0, 1'b0, "load_123");
      cycle(8'h55, 16'h4002, 1'b0, 1'b0, 1'b0, "hold_123");
      check("pre_rst.pc_const", prog_addr, 12'h123);
      check("pre_rst.ph_const", phase, 1'b1);
      pulse_reset("async_rst");
      check("async_rst.pc_const", prog_addr, 12'h000);
      cycle(8'h9A, 16'hC002, 1'b0, 1'b0, 1'b0, "post_rst");
      check("post_rst.op_const", operand, 4'hA);
      check("post_rst.pc_const", prog_addr, 12'h001);

`ifdef FETCH_STALL_EN
      for (int i = 0; i < 3; i++)
         cycle(8'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, "stall");
      check("stall.pc_const", prog_addr, 12'h001);
      check("stall.ph_const", phase, 1'b1);
      cycle(8'h42, 16'h0000, 1'b1, 1'b1, 1'b0, "resume");
      check("resume.pc_const", prog_addr, 12'hA42);
`endif

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(49) == 0)
            pulse_reset("rnd_rst");
         else
            cycle(8'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
`ifdef FETCH_STALL_EN
                  ($urandom_range(3) == 0),
`else
                  1'b0,
`endif
                  "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
